// File: rtl/fwd_ctrl_pkg.sv
// Shared pipeline definitions: forwarding select codes and the shadow
// stage record used by the forwarding/hazard controller.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_t;

endpackage

// File: rtl/fwd_ctrl_if.sv
// ID-stage request bundle and controller responses; the shadow stages are
// exported read-only so the pipeline can be traced alongside the CPU.
interface fwd_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  import pipe_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  stall;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [CNT_W-1:0]      stall_count;
  stage_t                ex_stage;
  stage_t                mem_stage;
  stage_t                wb_stage;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read,
    input  stall, fwd_a_sel, fwd_b_sel, stall_count,
           ex_stage, mem_stage, wb_stage
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read,
    output stall, fwd_a_sel, fwd_b_sel, stall_count,
           ex_stage, mem_stage, wb_stage
  );

endinterface

// File: rtl/fwd_ctrl_sel_calc.sv
// Per-operand forwarding select and load-use detection for one ID source.
module fwd_sel_calc
  import pipe_pkg::*;
(
  input  logic                  id_valid,
  input  logic                  use_rs,
  input  logic [REG_ADDR_W-1:0] rs,
  input  stage_t                ex,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  output logic [1:0]            sel,
  output logic                  hazard
);

  logic reading;
  logic ex_prod;
  logic mem_prod;

  assign reading  = id_valid & use_rs;
  assign ex_prod  = reading & ex.valid & ex.reg_write & (ex.rd != '0) & (ex.rd == rs);
  assign mem_prod = reading & mem_valid & mem_reg_write & (mem_rd != '0) & (mem_rd == rs);

  // A load in EX has no result until after MEM, so it cannot be forwarded yet.
  assign hazard = ex_prod & ex.mem_read;

  always_comb begin
    sel = FWD_RF;
    if (ex_prod)       sel = FWD_EXMEM;
    else if (mem_prod) sel = FWD_MEMWB;
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding/load-use controller: shadow EX/MEM/WB destination records,
// registered operand-mux selects and a saturating stall counter.
module fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic        clk,
  input logic        reset,
  fwd_ctrl_if.slave  bus
);
  import pipe_pkg::*;

  stage_t           id_s;
  stage_t           ex_q;
  stage_t           mem_q;
  stage_t           wb_q;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  logic             hz_a;
  logic             hz_b;
  logic             stall;
  logic [1:0]       fwd_a_q;
  logic [1:0]       fwd_b_q;
  logic [CNT_W-1:0] stall_cnt_q;

  assign id_s = '{valid:     bus.id_valid,
                  rd:        bus.id_rd,
                  reg_write: bus.id_reg_write,
                  mem_read:  bus.id_mem_read};

  fwd_sel_calc u_calc_a (
    .id_valid      (bus.id_valid),
    .use_rs        (bus.id_use_rs1),
    .rs            (bus.id_rs1),
    .ex            (ex_q),
    .mem_valid     (mem_q.valid),
    .mem_rd        (mem_q.rd),
    .mem_reg_write (mem_q.reg_write),
    .sel           (sel_a),
    .hazard        (hz_a)
  );

  fwd_sel_calc u_calc_b (
    .id_valid      (bus.id_valid),
    .use_rs        (bus.id_use_rs2),
    .rs            (bus.id_rs2),
    .ex            (ex_q),
    .mem_valid     (mem_q.valid),
    .mem_rd        (mem_q.rd),
    .mem_reg_write (mem_q.reg_write),
    .sel           (sel_b),
    .hazard        (hz_b)
  );

  assign stall = hz_a | hz_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else begin
      // On a stall EX takes a bubble, so its operand selects are irrelevant.
      ex_q    <= stall ? stage_t'('0) : id_s;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= stall ? FWD_RF : sel_a;
      fwd_b_q <= stall ? FWD_RF : sel_b;
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_a_sel   = fwd_a_q;
  assign bus.fwd_b_sel   = fwd_b_q;
  assign bus.stall_count = stall_cnt_q;
  assign bus.ex_stage    = ex_q;
  assign bus.mem_stage   = mem_q;
  assign bus.wb_stage    = wb_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: forwarding distances, load-use stalls, x0,
// priority, reset behaviour and counter saturation (CNT_W = 4).
module tb_fwd_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fwd_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();

  fwd_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic set_id(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2, input logic [AW-1:0] rd,
                        input logic rw, input logic mr);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_id(1, 5, 5, 1, 1, 5, 1, 1);
    step();
    for (int i = 0; i < 2; i++) begin
      set_id(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall[%0d]: got %b want 0", i, bus.stall); end
      n_cmp++; if (bus.fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL reset_sel_a[%0d]: got %b want 00", i, bus.fwd_a_sel); end
      n_cmp++; if (bus.fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL reset_sel_b[%0d]: got %b want 00", i, bus.fwd_b_sel); end
      n_cmp++; if (bus.stall_count !== 4'd0) begin n_bad++; $display("FAIL reset_count[%0d]: got %0d want 0", i, bus.stall_count); end
      step();
    end
    reset = 1'b1;
    // First cycle out of reset: a load-use-shaped ID still cannot stall.
    set_id(1, 5, 5, 1, 1, 6, 1, 0);
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL post_reset_stall: got %b want 0", bus.stall); end
    flush();
  endtask

  task automatic test_alu_alu();
    flush();
    set_id(1, 1, 2, 1, 1, 5, 1, 0);
    step();
    set_id(1, 5, 7, 1, 1, 6, 1, 0);
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL alu_alu_stall: got %b want 0", bus.stall); end
    step();
    n_cmp++; if (bus.fwd_a_sel !== 2'b01) begin n_bad++; $display("FAIL alu_alu_a: got %b want 01", bus.fwd_a_sel); end
    n_cmp++; if (bus.fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL alu_alu_b: got %b want 00", bus.fwd_b_sel); end
  endtask

  task automatic test_distance2();
    flush();
    set_id(1, 1, 2, 1, 1, 5, 1, 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_id(1, 7, 5, 1, 1, 8, 1, 0);
    step();
    n_cmp++; if (bus.fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL dist2_a: got %b want 00", bus.fwd_a_sel); end
    n_cmp++; if (bus.fwd_b_sel !== 2'b10) begin n_bad++; $display("FAIL dist2_b: got %b want 10", bus.fwd_b_sel); end
  endtask

  task automatic test_load_use();
    flush();
    n_cmp++; if (bus.stall_count !== 4'd0) begin n_bad++; $display("FAIL lu_count0: got %0d want 0", bus.stall_count); end
    set_id(1, 1, 0, 1, 0, 5, 1, 1);
    step();
    set_id(1, 5, 5, 1, 1, 6, 1, 0);
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
    step();
    n_cmp++; if (bus.stall_count !== 4'd1) begin n_bad++; $display("FAIL lu_count1: got %0d want 1", bus.stall_count); end
    n_cmp++; if (bus.fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL lu_bubble_a: got %b want 00", bus.fwd_a_sel); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_once: got %b want 0", bus.stall); end
    step();
    n_cmp++; if (bus.fwd_a_sel !== 2'b10) begin n_bad++; $display("FAIL lu_a: got %b want 10", bus.fwd_a_sel); end
    n_cmp++; if (bus.fwd_b_sel !== 2'b10) begin n_bad++; $display("FAIL lu_b: got %b want 10", bus.fwd_b_sel); end
    n_cmp++; if (bus.stall_count !== 4'd1) begin n_bad++; $display("FAIL lu_count_hold: got %0d want 1", bus.stall_count); end
  endtask

  task automatic test_x0_priority();
    flush();
    set_id(1, 1, 0, 1, 0, 0, 1, 0);
    step();
    set_id(1, 0, 0, 1, 1, 7, 1, 0);
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL x0_stall: got %b want 0", bus.stall); end
    step();
    n_cmp++; if (bus.fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL x0_a: got %b want 00", bus.fwd_a_sel); end
    n_cmp++; if (bus.fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL x0_b: got %b want 00", bus.fwd_b_sel); end
    flush();
    set_id(1, 1, 0, 1, 0, 0, 1, 1);
    step();
    set_id(1, 0, 0, 1, 1, 7, 1, 0);
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL x0_load_stall: got %b want 0", bus.stall); end
    flush();
    set_id(1, 1, 2, 1, 1, 5, 1, 0);
    step();
    set_id(1, 1, 2, 1, 1, 5, 1, 0);
    step();
    set_id(1, 5, 5, 1, 1, 9, 1, 0);
    step();
    n_cmp++; if (bus.fwd_a_sel !== 2'b01) begin n_bad++; $display("FAIL prio_a: got %b want 01", bus.fwd_a_sel); end
    n_cmp++; if (bus.fwd_b_sel !== 2'b01) begin n_bad++; $display("FAIL prio_b: got %b want 01", bus.fwd_b_sel); end
    flush();
    set_id(1, 1, 0, 1, 0, 5, 1, 1);
    step();
    set_id(1, 5, 5, 0, 0, 9, 1, 0);
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL nouse_stall: got %b want 0", bus.stall); end
    step();
    n_cmp++; if (bus.fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL nouse_a: got %b want 00", bus.fwd_a_sel); end
  endtask

  task automatic test_mid_stall_reset();
    flush();
    set_id(1, 1, 0, 1, 0, 5, 1, 1);
    step();
    set_id(1, 2, 5, 1, 1, 6, 1, 0);
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL msr_stall: got %b want 1", bus.stall); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_cmp++; if (bus.stall_count !== 4'd0) begin n_bad++; $display("FAIL msr_count: got %0d want 0", bus.stall_count); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL msr_stall_after: got %b want 0", bus.stall); end
    step();
    n_cmp++; if (bus.fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL msr_b: got %b want 00", bus.fwd_b_sel); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    flush();
    for (int i = 1; i <= 20; i++) begin
      set_id(1, 1, 0, 1, 0, 5, 1, 1);
      step();
      set_id(1, 5, 3, 1, 1, 6, 1, 0);
      step();
      step();
      exp_cnt = (i > 15) ? 15 : i;
      n_cmp++; if (bus.stall_count !== 4'(exp_cnt)) begin n_bad++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, bus.stall_count, exp_cnt); end
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_cmp++; if (bus.stall_count !== 4'd0) begin n_bad++; $display("FAIL sat_reset: got %0d want 0", bus.stall_count); end
  endtask

  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_alu();
    test_distance2();
    test_load_use();
    test_x0_priority();
    test_mid_stall_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Pipeline forwarding and load-use hazard controller for the 5-stage pipelined CPU. It keeps its own shadow copies of the destination-register fields for the EX, MEM and WB stages. From these it produces the registered 2-bit select codes that drive the two EX-stage operand `mux3to1` instances (ALU operands A and B), and it raises a one-cycle stall on load-use hazards. It sits beside the ID/EX pipeline register and is advanced by the same clock edge.

## Interface
Parameters:
- `REG_ADDR_W`, default 5: register index width.
- `CNT_W`, default 16: stall performance-counter width.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-low. Sampled on the rising edge of `clk`; 0 means reset.
- `id_valid`  in  1: the instruction in ID is real, not a bubble.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W each: source register indices in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each: the ID instruction reads that source.
- `id_rd`  in  REG_ADDR_W: destination register index in ID.
- `id_reg_write`  in  1: the ID instruction writes `id_rd`.
- `id_mem_read`  in  1: the ID instruction is a load.
- `stall`  out  1: combinational. Hold PC and IF/ID; insert a bubble into ID/EX.
- `fwd_a_sel`, `fwd_b_sel`  out  2 each: registered operand-mux selects for the instruction now in EX.
  - 00 = register-file value.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB write-back value.
  - 11 = never driven.
- `stall_count`  out  CNT_W: saturating count of stall cycles.

## Operation
- Shadow stage registers are kept for EX, MEM and WB. Each holds `{valid, rd, reg_write, mem_read}`.
- Each edge, the stages shift: ID → EX → MEM → WB.
  - When `stall`=1, EX loads a bubble (all fields 0). MEM and WB still shift.
- A stage is a "producer" for source `rs` when all of the following hold: valid, `reg_write`=1, `rd`!=0, `rd`==`rs`.
- Load-use hazard: `stall` = `id_valid` & EX.valid & EX.mem_read & EX.reg_write & (EX.rd!=0) & ((`id_use_rs1` & EX.rd==`id_rs1`) | (`id_use_rs2` & EX.rd==`id_rs2`)).
- Select computation happens in ID and is registered into `fwd_*_sel` at the edge that moves the instruction into EX. For each source:
  - If EX is a producer and the instruction is not stalled: 01. EX moves to MEM, so its result arrives via EX/MEM.
  - Else if MEM is a producer: 10. MEM moves to WB.
  - Else: 00. A WB-stage producer is covered by the write-first register file.
  - If the corresponding `id_use_rsN`=0, or `id_valid`=0: 00.
- Priority: the EX producer beats the MEM producer (youngest value wins).
- When `stall`=1, both `fwd_*_sel` are loaded with 00 because the EX stage holds a bubble.
- `stall_count` increments by 1 on every edge with `stall`=1 and saturates at all-ones.
- Register x0 is never forwarded and never causes a stall.

## Timing
- Reset (`reset`=0 at an edge) clears all shadow stages, `fwd_a_sel`=00, `fwd_b_sel`=00 and `stall_count`=0.
  - `stall` is 0 during reset and on the first cycle after it, because all stages are invalid.
- Reset asserted mid-stall clears the state on that edge. The counter does not increment on a reset edge.
- Selects have one cycle of latency: they are valid for the whole cycle the consumer sits in EX.
- A load-use hazard stalls for exactly one cycle.
  - Next cycle the load is in MEM and EX holds a bubble, so `stall`=0.
  - The consumer then enters EX with `fwd_*_sel`=10.
- A back-to-back load-use on both sources still costs one stall cycle.
- A consumer two instructions behind a load needs no stall and gets sel=10.
- Both operand selects are evaluated independently in the same cycle.

## Structure
- Shared package `pipe_pkg` holds:
  - Constants `FWD_RF`=2'b00, `FWD_EXMEM`=2'b01, `FWD_MEMWB`=2'b10.
  - `REG_ADDR_W`.
  - The stage-record typedef `{valid, rd, reg_write, mem_read}`.
- One sub-module, `fwd_sel_calc`: combinational per-operand select/hazard logic, instantiated twice (A and B).
- The top level holds the shadow stage registers, the select registers and the counter.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random inputs.
  - Required: sel=00/00, `stall`=0, `stall_count`=0 throughout.
- ALU→ALU: `add x5` followed immediately by `sub x6,x5,x7`.
  - Required: consumer in EX with `fwd_a_sel`=01 and `fwd_b_sel`=00. No stall.
- Distance-2: `add x5`, `nop`, `or x8,x7,x5`.
  - Required: `fwd_b_sel`=10.
- Load-use: `lw x5` followed by `add x6,x5,x5`.
  - Required: `stall`=1 for exactly one cycle.
  - Then the consumer in EX has A=10 and B=10.
  - `stall_count` goes 0→1.
- x0 and priority:
  - `addi x0` followed by a reader of x0 → 00, no stall.
  - `add x5`, `add x5`, then a reader of x5 → 01 (EX beats MEM).
- Saturation: with CNT_W=4, force 20 load-use stalls.
  - Required: `stall_count` holds at 15.
  - Then `reset`=0 for one edge returns it to 0.
